// File: rtl/mm_out_buffer.sv
// Accumulates K passes of partial-sum vectors in RAM, then requantises and streams the tile out.
// Latency: 2-cycle accumulate pipeline (1 vector/cycle); drain delivers its first vector 2 cycles after entering DRAIN.
// Backpressure: in_R_ready drops outside ACC and after the final pass is fully accepted; drain stalls on out_ready.
module mm_out_buffer #(
  parameter int A_size                  = 24,
  parameter int data_width              = 8,
  parameter int acc_width               = 32,
  parameter int Out_Block_num           = 2400,
  parameter int F_length_width          = 10,
  parameter int F_width_block_num_width = 5,
  parameter int W_width_block_num_width = 5,
  parameter int shift_width             = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [F_length_width-1:0]            F_length,
  input  logic [F_width_block_num_width-1:0]   F_width_block_num,
  input  logic [W_width_block_num_width-1:0]   W_width_block_num,
  input  logic [shift_width-1:0]               out_shift,
  input  logic                                 in_R_valid,
  output logic                                 in_R_ready,
  input  logic                                 in_R_last,
  input  logic [A_size*acc_width-1:0]          in_R_data,
  output logic                                 MM_buffer_out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic [A_size*data_width-1:0]         out_data,
  output logic                                 err_len
);

  localparam int AW = $clog2(Out_Block_num);
  localparam int PW = F_length_width + W_width_block_num_width;
  localparam int KW = F_width_block_num_width;
  localparam int VW = A_size * acc_width;
  localparam int OW = A_size * data_width;
  localparam int SMAX = 2 ** (data_width - 1) - 1;
  localparam logic signed [acc_width-1:0] SAT_MAX = acc_width'(SMAX);
  localparam logic signed [acc_width-1:0] SAT_MIN = acc_width'(-SMAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

  state_t                     state;
  logic [F_length_width-1:0]  cfg_f;
  logic [KW-1:0]              cfg_k;
  logic [W_width_block_num_width-1:0] cfg_w;
  logic [shift_width-1:0]     cfg_shift;
  logic [PW-1:0]              in_cnt;
  logic [KW-1:0]              pass_cnt;
  logic                       acc_done;
  logic                       s1_vld, s1_first, s1_final;
  logic [PW-1:0]              s1_addr;
  logic [VW-1:0]              s1_data;
  logic [VW-1:0]              rdq;
  logic [PW-1:0]              dr_cnt;
  logic                       dr_done;
  logic                       p1_vld, p1_last;
  logic [VW-1:0]              ram [0:Out_Block_num-1];

  logic [PW-1:0]              p_len, p_m1, rd_sel;
  logic [KW-1:0]              k_m1;
  logic                       acc_fire, wr_en, rd_en, out_free, p1_adv, dr_issue;
  logic [VW-1:0]              wr_data;
  logic [OW-1:0]              sat_data;

  assign p_len      = PW'(cfg_f) * PW'(cfg_w);
  assign p_m1       = p_len - PW'(1);
  assign k_m1       = cfg_k - KW'(1);
  assign in_R_ready = (state == S_ACC) && !acc_done;
  assign acc_fire   = in_R_valid && in_R_ready;
  assign wr_en      = s1_vld;
  assign out_free   = !out_valid || out_ready;
  assign p1_adv     = p1_vld && out_free;
  assign dr_issue   = (state == S_DRAIN) && !dr_done && (!p1_vld || out_free);
  assign rd_en      = acc_fire || dr_issue;
  assign rd_sel     = (state == S_DRAIN) ? dr_cnt : in_cnt;

  // Lane-wise accumulate: first pass overwrites stale RAM, later passes wrap-add.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < A_size; i++) begin
      wr_data[i*acc_width +: acc_width] = s1_first ? s1_data[i*acc_width +: acc_width]
                                                   : rdq[i*acc_width +: acc_width] + s1_data[i*acc_width +: acc_width];
    end
  end

  // Requantise the drained vector: arithmetic shift then clamp to the signed output range.
  always_comb begin
    logic signed [acc_width-1:0] sh;
    sat_data = '0;
    sh       = '0;
    for (int i = 0; i < A_size; i++) begin
      sh = $signed(rdq[i*acc_width +: acc_width]) >>> cfg_shift;
      if (sh > SAT_MAX)      sh = SAT_MAX;
      else if (sh < SAT_MIN) sh = SAT_MIN;
      sat_data[i*data_width +: data_width] = sh[data_width-1:0];
    end
  end

  // Accumulator RAM; a write landing on the address being read is forwarded (back-to-back P=1 passes).
  always_ff @(posedge clk) begin
    if (wr_en) ram[s1_addr[AW-1:0]] <= wr_data;
    if (rd_en) rdq <= (wr_en && (s1_addr == rd_sel)) ? wr_data : ram[rd_sel[AW-1:0]];
  end

  // Control FSM: config capture, pass/vector counting, accumulate stage 1 and drain pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cfg_f              <= '0;
      cfg_k              <= '0;
      cfg_w              <= '0;
      cfg_shift          <= '0;
      in_cnt             <= '0;
      pass_cnt           <= '0;
      acc_done           <= 1'b0;
      s1_vld             <= 1'b0;
      s1_first           <= 1'b0;
      s1_final           <= 1'b0;
      s1_addr            <= '0;
      s1_data            <= '0;
      dr_cnt             <= '0;
      dr_done            <= 1'b0;
      p1_vld             <= 1'b0;
      p1_last            <= 1'b0;
      MM_buffer_out_last <= 1'b0;
      out_valid          <= 1'b0;
      out_last           <= 1'b0;
      out_data           <= '0;
      err_len            <= 1'b0;
    end else begin
      MM_buffer_out_last <= s1_vld && (s1_addr == p_m1);
      s1_vld             <= acc_fire;
      if (acc_fire) begin
        s1_addr  <= in_cnt;
        s1_data  <= in_R_data;
        s1_first <= (pass_cnt == '0);
        s1_final <= (pass_cnt == k_m1);
      end
      case (state)
        S_IDLE: begin
          if (in_R_valid) begin
            state     <= S_ACC;
            cfg_f     <= F_length;
            cfg_k     <= F_width_block_num;
            cfg_w     <= W_width_block_num;
            cfg_shift <= out_shift;
            in_cnt    <= '0;
            pass_cnt  <= '0;
            acc_done  <= 1'b0;
            dr_cnt    <= '0;
            dr_done   <= 1'b0;
            p1_vld    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        S_ACC: begin
          if (acc_fire) begin
            if (in_R_last != (in_cnt == p_m1)) err_len <= 1'b1;
            if (in_cnt == p_m1) begin
              in_cnt <= '0;
              if (pass_cnt == k_m1) acc_done <= 1'b1;
              else                  pass_cnt <= pass_cnt + KW'(1);
            end else begin
              in_cnt <= in_cnt + PW'(1);
            end
          end
          if (s1_vld && s1_final && (s1_addr == p_m1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (dr_issue) begin
            p1_vld  <= 1'b1;
            p1_last <= (dr_cnt == p_m1);
            if (dr_cnt == p_m1) dr_done <= 1'b1;
            else                dr_cnt  <= dr_cnt + PW'(1);
          end else if (p1_adv) begin
            p1_vld <= 1'b0;
          end
          if (p1_adv) begin
            out_valid <= 1'b1;
            out_data  <= sat_data;
            out_last  <= p1_last;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (out_valid && out_ready && out_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_out_buffer.sv
module tb_mm_out_buffer;
  localparam int A  = 24;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int VW = A * CW;
  localparam int OW = A * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    F_length;
  logic [4:0]    F_width_block_num;
  logic [4:0]    W_width_block_num;
  logic [4:0]    out_shift;
  logic          in_R_valid, in_R_ready, in_R_last;
  logic [VW-1:0] in_R_data;
  logic          MM_buffer_out_last;
  logic          out_valid, out_ready, out_last;
  logic [OW-1:0] out_data;
  logic          err_len;

  int compared   = 0;
  int mismatched = 0;
  int mm_cnt     = 0;
  int m0;
  logic [OW-1:0] exp_q[$];
  logic [VW-1:0] vtmp;
  logic [OW-1:0] otmp;

  always #5 clk = ~clk;

  always @(negedge clk) if (MM_buffer_out_last === 1'b1) mm_cnt++;

  mm_out_buffer #(
    .A_size(A), .data_width(DW), .acc_width(CW), .Out_Block_num(2400),
    .F_length_width(10), .F_width_block_num_width(5), .W_width_block_num_width(5), .shift_width(5)
  ) dut (
    .clk(clk), .rst(rst), .F_length(F_length), .F_width_block_num(F_width_block_num),
    .W_width_block_num(W_width_block_num), .out_shift(out_shift),
    .in_R_valid(in_R_valid), .in_R_ready(in_R_ready), .in_R_last(in_R_last), .in_R_data(in_R_data),
    .MM_buffer_out_last(MM_buffer_out_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_data(out_data), .err_len(err_len)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < A; i++) r[i*CW +: CW] = v[CW-1:0];
    return r;
  endfunction

  function automatic logic [OW-1:0] ofill(input int v);
    logic [OW-1:0] r;
    for (int i = 0; i < A; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [VW-1:0] fill3(input int a, input int b, input int c);
    logic [VW-1:0] r;
    for (int i = 0; i < A; i++) r[i*CW +: CW] = (i % 3 == 0) ? a[CW-1:0] : (i % 3 == 1) ? b[CW-1:0] : c[CW-1:0];
    return r;
  endfunction

  function automatic logic [OW-1:0] ofill3(input int a, input int b, input int c);
    logic [OW-1:0] r;
    for (int i = 0; i < A; i++) r[i*DW +: DW] = (i % 3 == 0) ? a[DW-1:0] : (i % 3 == 1) ? b[DW-1:0] : c[DW-1:0];
    return r;
  endfunction

  task automatic cfg(input int f, input int w, input int k, input int s);
    F_length          = f[9:0];
    W_width_block_num = w[4:0];
    F_width_block_num = k[4:0];
    out_shift         = s[4:0];
  endtask

  // Present one vector at a negedge; it is accepted at the first posedge where in_R_ready is high.
  task automatic send(input logic [VW-1:0] d, input logic last);
    int t = 0;
    in_R_valid = 1'b1;
    in_R_data  = d;
    in_R_last  = last;
    while (in_R_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (in_R_ready !== 1'b1) chk("send_ready", {{(VW-1){1'b0}}, in_R_ready}, 1);
    @(negedge clk);
    in_R_valid = 1'b0;
    in_R_last  = 1'b0;
  endtask

  // Collect n outputs against exp_q, checking hold-under-stall, order and out_last placement.
  task automatic drain(input int n, input bit rnd);
    int            idx = 0;
    int            cyc = 0;
    bit            stalled = 0;
    bit            rdy_seen = 0;
    logic [OW-1:0] held = '0;
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (in_R_ready === 1'b1) rdy_seen = 1;
      if (stalled) begin
        chk("stall_valid", {{(VW-1){1'b0}}, out_valid}, 1);
        chk("stall_data", out_data, held);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          chk($sformatf("out_data[%0d]", idx), out_data, exp_q[idx]);
          chk($sformatf("out_last[%0d]", idx), {{(VW-1){1'b0}}, out_last}, (idx == n - 1) ? 1 : 0);
          idx++;
        end else begin
          stalled = 1;
          held    = out_data;
        end
      end
    end
    chk("drain_count", idx, n);
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_last", {{(VW-1){1'b0}}, out_valid}, 0);
    chk("in_ready_in_drain", {{(VW-1){1'b0}}, rdy_seen}, 0);
  endtask

  initial begin
    rst        = 1'b1;
    in_R_valid = 1'b0;
    in_R_last  = 1'b0;
    in_R_data  = '0;
    out_ready  = 1'b0;
    cfg(1, 1, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {{(VW-1){1'b0}}, in_R_ready}, 0);
    chk("rst_out_valid", {{(VW-1){1'b0}}, out_valid}, 0);
    chk("rst_out_last", {{(VW-1){1'b0}}, out_last}, 0);
    chk("rst_mm_last", {{(VW-1){1'b0}}, MM_buffer_out_last}, 0);
    chk("rst_err_len", {{(VW-1){1'b0}}, err_len}, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: P=8, K=1, vector n has every lane = n
    cfg(4, 2, 1, 0);
    exp_q.delete();
    m0 = mm_cnt;
    for (int n = 0; n < 8; n++) send(fill(n), n == 7);
    for (int n = 0; n < 8; n++) exp_q.push_back(ofill(n));
    drain(8, 0);
    chk("t1_mm_pulses", mm_cnt - m0, 1);

    // 2: P=8, K=3, lanes 10 each pass -> 30
    cfg(4, 2, 3, 0);
    exp_q.delete();
    m0 = mm_cnt;
    for (int p = 0; p < 3; p++)
      for (int n = 0; n < 8; n++) send(fill(10), n == 7);
    for (int n = 0; n < 8; n++) exp_q.push_back(ofill(30));
    drain(8, 0);
    chk("t2_mm_pulses", mm_cnt - m0, 3);

    // 3: saturation with shift 2: 1000->127, -1000->-128, -5->-2
    cfg(2, 1, 1, 2);
    exp_q.delete();
    send(fill3(1000, -1000, -5), 1'b0);
    send(fill3(-5, 1000, -1000), 1'b1);
    exp_q.push_back(ofill3(127, -128, -2));
    exp_q.push_back(ofill3(-2, 127, -128));
    drain(2, 0);

    // 4: P=1, K=4, back-to-back lanes 7 -> 28 through the forwarding path
    cfg(1, 1, 4, 0);
    exp_q.delete();
    m0 = mm_cnt;
    for (int p = 0; p < 4; p++) send(fill(7), 1'b1);
    exp_q.push_back(ofill(28));
    drain(1, 0);
    chk("t4_mm_pulses", mm_cnt - m0, 4);

    // 5: P=8, K=2, lane i of vector n = n+i, shift 1 -> n+i; random out_ready
    cfg(2, 4, 2, 1);
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int n = 0; n < 8; n++) begin
        for (int i = 0; i < A; i++) vtmp[i*CW +: CW] = CW'(n + i);
        send(vtmp, n == 7);
      end
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < A; i++) otmp[i*DW +: DW] = DW'(n + i);
      exp_q.push_back(otmp);
    end
    drain(8, 1);

    // 6: early in_R_last sets sticky err_len; reset mid-ACC; next tile is clean
    cfg(8, 1, 2, 0);
    for (int n = 0; n < 4; n++) send(fill(1), n == 2);
    chk("t6_err_set", {{(VW-1){1'b0}}, err_len}, 1);
    send(fill(1), 1'b0);
    send(fill(1), 1'b0);
    @(negedge clk);
    chk("t6_err_sticky", {{(VW-1){1'b0}}, err_len}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", {{(VW-1){1'b0}}, in_R_ready}, 0);
    chk("t6_rst_out_valid", {{(VW-1){1'b0}}, out_valid}, 0);
    chk("t6_rst_out_last", {{(VW-1){1'b0}}, out_last}, 0);
    chk("t6_rst_mm_last", {{(VW-1){1'b0}}, MM_buffer_out_last}, 0);
    chk("t6_rst_err_len", {{(VW-1){1'b0}}, err_len}, 0);
    chk("t6_rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    cfg(2, 1, 1, 0);
    exp_q.delete();
    send(fill(3), 1'b0);
    send(fill(-4), 1'b1);
    exp_q.push_back(ofill(3));
    exp_q.push_back(ofill(-4));
    drain(2, 0);
    chk("t6_err_clean", {{(VW-1){1'b0}}, err_len}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
